// File: rtl/switch_pkg.sv
// Shared defaults and sizing constants for the board switch debouncer.
package switch_pkg;

  localparam int unsigned SW_WIDTH_DEF = 24;
  localparam int unsigned TICK_DIV_DEF = 100000;
  localparam int unsigned NSAMP_DEF    = 4;

  // Wide enough for the largest legal terminal count, 2^20 - 1.
  localparam int unsigned TICK_CNT_W   = 20;

endpackage

// File: rtl/switch_tick.sv
// Free-running sample-tick divider: o_tick is high while the count sits at TICK_DIV-1.
module switch_tick
  import switch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam logic [TICK_CNT_W-1:0] LAST = TICK_CNT_W'(TICK_DIV - 1);

  logic [TICK_CNT_W-1:0] r_cnt;
  logic                  w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = w_wrap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Synchronise, sample and debounce board switches. Change pulse and sticky
// change mask are built only when SWITCH_CHG_IRQ_EN is defined.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int unsigned SW_WIDTH = SW_WIDTH_DEF,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned NSAMP    = NSAMP_DEF
) (
  input  logic                debclk,
  input  logic                debrst,
  input  logic [SW_WIDTH-1:0] switch_raw,
  output logic [SW_WIDTH-1:0] switch_o,
  output logic                switch_chg,
  output logic [SW_WIDTH-1:0] switch_chgmask,
  input  logic                switch_chgclr
);

  logic [SW_WIDTH-1:0] r_sync1;
  logic [SW_WIDTH-1:0] r_sync2;
  logic [NSAMP-1:0]    r_hist [SW_WIDTH];
  logic [SW_WIDTH-1:0] r_level;
  logic [SW_WIDTH-1:0] w_level_nxt;
  logic                w_tick;

  switch_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .i_clk (debclk),
    .i_rst (debrst),
    .o_tick(w_tick)
  );

  always_ff @(posedge debclk) begin
    if (debrst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      for (int unsigned i = 0; i < SW_WIDTH; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      r_sync1 <= switch_raw;
      r_sync2 <= r_sync1;
      r_level <= w_level_nxt;
      if (w_tick) begin
        for (int unsigned i = 0; i < SW_WIDTH; i++) begin
          r_hist[i] <= {r_hist[i][NSAMP-2:0], r_sync2[i]};
        end
      end
    end
  end

  // History only moves on a tick, so evaluating it every cycle lands the
  // decision exactly one cycle after the tick that completed it.
  always_comb begin
    w_level_nxt = r_level;
    for (int unsigned i = 0; i < SW_WIDTH; i++) begin
      if (&r_hist[i]) begin
        w_level_nxt[i] = 1'b1;
      end else if (~|r_hist[i]) begin
        w_level_nxt[i] = 1'b0;
      end
    end
  end

  assign switch_o = r_level;

`ifdef SWITCH_CHG_IRQ_EN
  logic [SW_WIDTH-1:0] w_diff;
  logic [SW_WIDTH-1:0] r_chgmask;
  logic                r_chg;

  // Detect on the next-state value so the pulse coincides with the new level.
  assign w_diff = w_level_nxt ^ r_level;

  always_ff @(posedge debclk) begin
    if (debrst) begin
      r_chg     <= 1'b0;
      r_chgmask <= '0;
    end else begin
      r_chg     <= |w_diff;
      r_chgmask <= switch_chgclr ? w_diff : (r_chgmask | w_diff);
    end
  end

  assign switch_chg     = r_chg;
  assign switch_chgmask = r_chgmask;
`else
  logic w_unused_chgclr;

  assign w_unused_chgclr = switch_chgclr;
  assign switch_chg      = 1'b0;
  assign switch_chgmask  = '0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce against a run-length reference model.
module tb_switch_debounce;

  localparam int unsigned W  = 24;
  localparam int unsigned TD = 4;
  localparam int unsigned NS = 3;
`ifdef SWITCH_CHG_IRQ_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic [W-1:0] raw;
  logic [W-1:0] sw_o;
  logic         chg;
  logic [W-1:0] mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_debounce #(
    .SW_WIDTH(W),
    .TICK_DIV(TD),
    .NSAMP   (NS)
  ) dut (
    .debclk        (clk),
    .debrst        (rst),
    .switch_raw    (raw),
    .switch_o      (sw_o),
    .switch_chg    (chg),
    .switch_chgmask(mask),
    .switch_chgclr (clr)
  );

  // Reference model: pin delayed two edges, sampled every TD-th cycle after
  // reset, accepted once NS equal samples in a row have been seen.
  logic [W-1:0] m_d1, m_d2, m_out, m_mask;
  logic         m_chg;
  int unsigned  m_cnt;
  int unsigned  m_ones  [W];
  int unsigned  m_zeros [W];

  function automatic logic [W-1:0] m_decide();
    logic [W-1:0] r;
    r = m_out;
    for (int b = 0; b < W; b++) begin
      if (m_ones[b] >= NS)       r[b] = 1'b1;
      else if (m_zeros[b] >= NS) r[b] = 1'b0;
    end
    return r;
  endfunction

  function automatic bit will_change(int b);
    logic [W-1:0] n;
    n = m_decide();
    return n[b] != m_out[b];
  endfunction

  task automatic model_edge();
    logic [W-1:0] nxt, diff;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_out = '0; m_mask = '0; m_chg = 1'b0; m_cnt = 0;
      for (int b = 0; b < W; b++) begin
        m_ones[b] = 0; m_zeros[b] = NS;
      end
    end else begin
      nxt    = m_decide();
      diff   = nxt ^ m_out;
      m_chg  = |diff;
      m_mask = clr ? diff : (m_mask | diff);
      m_out  = nxt;
      if (m_cnt == TD - 1) begin
        for (int b = 0; b < W; b++) begin
          if (m_d2[b]) begin m_ones[b]++;  m_zeros[b] = 0; end
          else         begin m_zeros[b]++; m_ones[b]  = 0; end
        end
      end
      m_cnt = (m_cnt + 1) % TD;
      m_d2  = m_d1;
      m_d1  = raw;
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_o", sw_o, m_out);
    check("model_chg", {{(W-1){1'b0}}, chg}, CHG_EN ? {{(W-1){1'b0}}, m_chg} : '0);
    check("model_mask", mask, CHG_EN ? m_mask : '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ticks;
    int unsigned idx;

    // Reset with all switches high
    rst = 1'b1; clr = 1'b0; raw = '1;
    repeat (3) begin
      step();
      check("rst_o", sw_o, '0);
      check("rst_chg", {{(W-1){1'b0}}, chg}, '0);
      check("rst_mask", mask, '0);
    end
    rst = 1'b0; raw = '0;
    repeat (16) step();
    check("post_rst_chg", {{(W-1){1'b0}}, chg}, '0);

    // Clean rising edge on bit 0
    raw[0] = 1'b1;
    n = 0;
    while (sw_o[0] !== 1'b1 && n < 20) begin step(); n++; end
    check("clean_latency", {{(W-1){1'b0}}, (n <= 15)}, 24'h1);
    check("clean_chg", {{(W-1){1'b0}}, chg}, CHG_EN ? 24'h1 : 24'h0);
    step();
    check("clean_chg_end", {{(W-1){1'b0}}, chg}, '0);
    check("clean_mask", mask, CHG_EN ? 24'h000001 : 24'h0);

    // Bounce on bit 5, phased so every tick samples the low half
    for (int k = 0; k < 40; k++) begin
      raw[5] = (m_cnt >= 2);
      step();
      check("bounce_o5", {{(W-1){1'b0}}, sw_o[5]}, '0);
      check("bounce_chg", {{(W-1){1'b0}}, chg}, '0);
    end
    raw[5] = 1'b0;
    repeat (8) begin
      step();
      check("bounce_hold_o5", {{(W-1){1'b0}}, sw_o[5]}, '0);
    end

    // Clear asserted at the edge that raises bit 23
    raw[23] = 1'b1;
    n = 0;
    while (!will_change(23) && n < 30) begin step(); n++; end
    check("race_found", {{(W-1){1'b0}}, (n < 30)}, 24'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("race_o23", {{(W-1){1'b0}}, sw_o[23]}, 24'h1);
    check("race_mask", mask, CHG_EN ? 24'h800000 : 24'h0);

    // Reset in the middle of a debounce
    raw = 24'h00F000;
    ticks = 0; n = 0;
    while (ticks < 2 && n < 40) begin
      if (m_cnt == TD - 1) ticks++;
      step(); n++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("rstmid_hold", sw_o, '0);
      if (k == 1) check("rstmid_nochg", {{(W-1){1'b0}}, chg}, '0);
    end
    step();
    check("rstmid_accept", sw_o, 24'h00F000);
    check("rstmid_chg", {{(W-1){1'b0}}, chg}, CHG_EN ? 24'h1 : 24'h0);

    // Random toggles, short glitches and clears
    repeat (500) begin
      if ($urandom_range(0, 11) == 0) begin
        idx = $urandom_range(0, W - 1);
        raw[idx] = ~raw[idx];
      end
      clr = ($urandom_range(0, 7) == 0);
      step();
    end
    clr = 1'b0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter SW_WIDTH, default 24: number of board switch inputs handled.
REQ-002 Parameter TICK_DIV, default 100000: clock cycles per sample tick (1 ms at 100 MHz); legal range 2..2^20.
REQ-003 Parameter NSAMP, default 4: consecutive equal samples required to accept a new level; legal range 2..8.
REQ-004 Port debclk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port debrst  input  1: reset, synchronous, active-high.
REQ-006 Port switch_raw  input  SW_WIDTH: asynchronous, bouncing pin levels from the board switches.
REQ-007 Port switch_o  output  SW_WIDTH: debounced, synchronised levels; drives switch_i of the switch read port.
REQ-008 Port switch_chg  output  1: one-cycle pulse when any switch_o bit changes (SWITCH_CHG_IRQ_EN only).
REQ-009 Port switch_chgmask  output  SW_WIDTH: sticky per-bit changed flags (SWITCH_CHG_IRQ_EN only).
REQ-010 Port switch_chgclr  input  1: clears switch_chgmask (SWITCH_CHG_IRQ_EN only).

Function
REQ-011 Each switch_raw bit SHALL pass through a two-flop synchroniser before any other use.
REQ-012 A tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert an internal tick in the cycle it equals TICK_DIV-1.
REQ-013 On tick, each bit's synchronised level SHALL shift into a per-bit NSAMP-deep history register.
REQ-014 switch_o[i] SHALL become 1 the cycle after a tick leaves history[i] all ones, 0 if all zeros, otherwise hold.
REQ-015 A level held stable at switch_raw SHALL appear on switch_o within 2 + NSAMP*TICK_DIV + 1 cycles.
REQ-016 A glitch shorter than one tick period SHALL never change switch_o.
REQ-017 switch_chg SHALL pulse high for exactly one cycle, coincident with the first cycle switch_o differs from its previous value.
REQ-018 switch_chgmask[i] SHALL set when switch_o[i] changes and hold until switch_chgclr is high.
REQ-019 With switch_chgclr high and a change in the same cycle, the mask SHALL load exactly the newly changed bits (new change wins).
REQ-020 Multiple bits changing on one tick SHALL produce a single switch_chg pulse and set all corresponding mask bits.

Reset
REQ-021 While debrst is high at a debclk edge: synchroniser flops, history registers, tick counter, switch_o, switch_chg and switch_chgmask SHALL all load 0.
REQ-022 Reset asserted mid-count or mid-debounce SHALL discard partial history; counting restarts from 0 on the first cycle debrst is low.
REQ-023 Leaving reset SHALL NOT by itself produce a switch_chg pulse.

Configuration
REQ-024 Macro SWITCH_CHG_IRQ_EN defined: change-detect logic (REQ-017..REQ-020) SHALL be built.
REQ-025 Macro SWITCH_CHG_IRQ_EN undefined: switch_chg and switch_chgmask SHALL be tied to 0, switch_chgclr ignored, no change-detect flops built; debounce behaviour unchanged.

Structure
REQ-026 Package switch_pkg SHALL hold SW_WIDTH default 24, TICK_DIV/NSAMP defaults and the tick counter width constant.
REQ-027 Tick generation SHALL be a separate sub-module switch_tick (clock, reset, tick output, TICK_DIV parameter); bit-level logic stays in switch_debounce.

Verification (bench uses TICK_DIV=4, NSAMP=3, SWITCH_CHG_IRQ_EN defined unless stated)
REQ-028 Reset: debrst high 3 cycles with switch_raw=24'hFFFFFF -> switch_o=0, switch_chg=0, switch_chgmask=0 throughout reset.
REQ-029 Clean edge: switch_raw[0] 0->1 and held -> switch_o[0]=1 within 2+12+1=15 cycles, switch_chg one-cycle pulse, switch_chgmask=24'h000001.
REQ-030 Bounce: switch_raw[5] toggled every 2 cycles for 40 cycles then held 0 -> switch_o[5] stays 0, no switch_chg pulse.
REQ-031 Clear race: switch_chgmask=24'h000001, switch_chgclr high in the cycle switch_o[23] rises -> switch_chgmask=24'h800000 next cycle.
REQ-032 Reset mid-debounce: switch_raw=24'h00F000, debrst pulsed after 2 ticks -> switch_o stays 0 until 3 full ticks after reset release.
REQ-033 Macro off: rerun REQ-029 without SWITCH_CHG_IRQ_EN -> switch_o identical, switch_chg and switch_chgmask constant 0.
